dec_vtp_decoder: RTL and testbench

DEC_VTP_DECODER -- requirements
Module: dec_vtp

---
 rtl/dec_vtp_decoder.sv | 93 +++++++++
 tb/tb_dec_vtp_decoder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_vtp_decoder.sv
// rtl/dec_vtp_decoder.sv - butterfly-network virtual-to-physical line address decoder
// Optional macro DEC_VTP_PIPE_EN inserts a pipeline register at the network midpoint.
module dec_vtp_decoder #(
  parameter int BITMAP  = 512,
  parameter int OREG_EN = 1
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst,
  input  logic [$clog2(BITMAP):0]                      i_vaddr,
  input  logic [$clog2(BITMAP)-1:0][BITMAP/2-1:0]      i_scb,
  output logic [$clog2(BITMAP)-1:0]                    o_paddr
);

  localparam int BLOCK_W = $clog2(BITMAP);
  localparam int NODES   = BITMAP / 2;
  localparam int STAGES  = BLOCK_W;
  localparam int HALF    = STAGES / 2;
  localparam int REM     = STAGES - HALF;

  // Stage s: the node is addressed by a with bit s removed; its control bit flips bit s.
  function automatic logic [BLOCK_W-1:0] stage_step(input logic [BLOCK_W-1:0] a,
                                                    input logic [NODES-1:0]   row,
                                                    input int                 s);
    logic [BLOCK_W-1:0] lo;
    logic [BLOCK_W-1:0] hi;
    logic [BLOCK_W-2:0] n;
    lo = a & ((BLOCK_W'(1) << s) - BLOCK_W'(1));
    hi = (a >> (s + 1)) << s;
    n  = (BLOCK_W-1)'(hi | lo);
    return a ^ (BLOCK_W'(row[n]) << s);
  endfunction

  logic [BLOCK_W-1:0]          mid_d;
  logic [BLOCK_W-1:0]          mid_src;
  logic [REM-1:0][NODES-1:0]   scb_src;
  logic [BLOCK_W-1:0]          paddr_d;
  logic                        unused_in;

  assign unused_in = ^{i_vaddr[BLOCK_W], i_clk, i_rst};

  always_comb begin
    mid_d = i_vaddr[BLOCK_W-1:0];
    for (int s = 0; s < HALF; s++) begin
      mid_d = stage_step(mid_d, i_scb[s], s);
    end
  end

`ifdef DEC_VTP_PIPE_EN
  logic [BLOCK_W-1:0]        mid_q;
  logic [REM-1:0][NODES-1:0] scb_q;

  // Back half of the network uses the switch rows captured alongside the midpoint address.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mid_q <= '0;
      scb_q <= '0;
    end else begin
      mid_q <= mid_d;
      scb_q <= i_scb[STAGES-1:HALF];
    end
  end

  assign mid_src = mid_q;
  assign scb_src = scb_q;
`else
  assign mid_src = mid_d;
  assign scb_src = i_scb[STAGES-1:HALF];
`endif

  always_comb begin
    paddr_d = mid_src;
    for (int s = HALF; s < STAGES; s++) begin
      paddr_d = stage_step(paddr_d, scb_src[s-HALF], s);
    end
  end

  generate
    if (OREG_EN != 0) begin : g_oreg
      logic [BLOCK_W-1:0] paddr_q;
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          paddr_q <= '0;
        end else begin
          paddr_q <= paddr_d;
        end
      end
      assign o_paddr = paddr_q;
    end else begin : g_comb
      assign o_paddr = paddr_d;
    end
  endgenerate

endmodule

// File: tb/tb_dec_vtp_decoder.sv
// tb/tb_dec_vtp_decoder.sv - self-checking bench for dec_vtp_decoder (BITMAP 512/8, OREG_EN 1/0)
module tb_dec_vtp_decoder;

`ifdef DEC_VTP_PIPE_EN
  localparam int LAT  = 2;
  localparam int LAT0 = 1;
`else
  localparam int LAT  = 1;
  localparam int LAT0 = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [9:0]       vaddr;
  logic [8:0][255:0] scb;
  logic [8:0]       paddr;
  logic [8:0]       paddr0;
  logic [3:0]       vaddr8;
  logic [2:0][3:0]  scb8;
  logic [2:0]       paddr8;

  int checks = 0;
  int errors = 0;
  bit m[9][256];
  bit m8[9][256];

  always #5 clk = ~clk;

  dec_vtp_decoder #(.BITMAP(512), .OREG_EN(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_vaddr(vaddr), .i_scb(scb), .o_paddr(paddr));
  dec_vtp_decoder #(.BITMAP(512), .OREG_EN(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_vaddr(vaddr), .i_scb(scb), .o_paddr(paddr0));
  dec_vtp_decoder #(.BITMAP(8), .OREG_EN(1)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_vaddr(vaddr8), .i_scb(scb8), .o_paddr(paddr8));

  // Reference: walk the stages with integer arithmetic on the line number.
  function automatic int ref_dec(input int v, input int w, input bit sw[9][256]);
    int a;
    int n;
    a = v % (1 << w);
    for (int s = 0; s < w; s++) begin
      n = (a % (1 << s)) + (a / (1 << (s + 1))) * (1 << s);
      if (sw[s][n]) begin
        if ((a / (1 << s)) % 2 == 1) a = a - (1 << s);
        else a = a + (1 << s);
      end
    end
    return a;
  endfunction

  task automatic load_m(input int mode);
    for (int s = 0; s < 9; s++)
      for (int n = 0; n < 256; n++)
        m[s][n] = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'(mode);
    for (int s = 0; s < 9; s++)
      for (int n = 0; n < 256; n++)
        scb[s][n] = m[s][n];
  endtask

  task automatic load_m8();
    for (int s = 0; s < 3; s++)
      for (int n = 0; n < 4; n++)
        scb8[s][n] = m8[s][n];
  endtask

  task automatic apply(input int v);
    @(negedge clk);
    vaddr = 10'(v);
    repeat (LAT) @(posedge clk);
    #1;
  endtask

  task automatic apply8(input int v);
    @(negedge clk);
    vaddr8 = 4'(v);
    repeat (LAT) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; vaddr = '0; scb = '0; vaddr8 = '0; scb8 = '0;
    #1;
    checks++;
    if (paddr !== 9'd0) begin errors++; $display("FAIL reset_paddr got %0h exp 0", paddr); end
    checks++;
    if (paddr8 !== 3'd0) begin errors++; $display("FAIL reset_paddr8 got %0h exp 0", paddr8); end
    load_m(1);
    vaddr = 10'd5; vaddr8 = 4'd5;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (paddr !== 9'd0) begin errors++; $display("FAIL reset_hold got %0h exp 0", paddr); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_identity();
    load_m(0);
    apply(10'h1FF);
    checks++;
    if (paddr !== 9'h1FF) begin errors++; $display("FAIL ident_1ff got %0h exp 1ff", paddr); end
    apply(5);
    checks++;
    if (paddr !== 9'd5) begin errors++; $display("FAIL ident_5 got %0h exp 5", paddr); end
  endtask

  task automatic test_complement();
    load_m(1);
    apply(0);
    checks++;
    if (paddr !== 9'd511) begin errors++; $display("FAIL compl_0 got %0h exp 1ff", paddr); end
    apply(511);
    checks++;
    if (paddr !== 9'd0) begin errors++; $display("FAIL compl_511 got %0h exp 0", paddr); end
  endtask

  task automatic test_bitmap8();
    int vin[5]  = '{0, 1, 2, 0, 4};
    int vexp[5] = '{1, 0, 2, 4, 0};
    for (int i = 0; i < 5; i++) begin
      for (int s = 0; s < 9; s++)
        for (int n = 0; n < 256; n++) m8[s][n] = 1'b0;
      if (i < 3) m8[0][0] = 1'b1;
      else m8[2][0] = 1'b1;
      load_m8();
      apply8(vin[i]);
      checks++;
      if (int'(paddr8) !== vexp[i] || vexp[i] !== ref_dec(vin[i], 3, m8)) begin
        errors++;
        $display("FAIL bm8_case%0d got %0d exp %0d", i, paddr8, vexp[i]);
      end
    end
    for (int t = 0; t < 16; t++) begin
      int v;
      for (int s = 0; s < 3; s++)
        for (int n = 0; n < 4; n++) m8[s][n] = 1'($urandom_range(0, 1));
      load_m8();
      v = $urandom_range(0, 15);
      apply8(v);
      checks++;
      if (int'(paddr8) !== ref_dec(v, 3, m8)) begin
        errors++;
        $display("FAIL bm8_rand v=%0d got %0d exp %0d", v, paddr8, ref_dec(v, 3, m8));
      end
    end
  endtask

  task automatic test_random_sweep();
    bit seen[512];
    int dup;
    logic [8:0] first;
    dup = 0;
    load_m(2);
    for (int v = 0; v < 512; v++) begin
      apply(v);
      first = paddr;
      checks++;
      if (int'(first) !== ref_dec(v, 9, m)) begin
        errors++;
        $display("FAIL sweep v=%0d got %0h exp %0h", v, first, ref_dec(v, 9, m));
      end
      if (seen[first]) dup++;
      seen[first] = 1'b1;
      if (v % 16 == 0) begin
        apply(v + 512);
        checks++;
        if (paddr !== first) begin
          errors++;
          $display("FAIL msb_toggle v=%0d got %0h exp %0h", v, paddr, first);
        end
      end
    end
    checks++;
    if (dup !== 0) begin errors++; $display("FAIL bijection dups got %0d exp 0", dup); end
  endtask

  task automatic test_back_to_back();
    int q[$];
    int exp_v;
    int v;
    load_m(2);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i >= LAT) begin
        exp_v = q.pop_front();
        checks++;
        if (int'(paddr) !== exp_v) begin
          errors++;
          $display("FAIL b2b cycle %0d got %0h exp %0h", i, paddr, exp_v);
        end
      end
      if (i % 50 == 25) load_m(2);
      v = $urandom_range(0, 1023);
      vaddr = 10'(v);
      q.push_back(ref_dec(v, 9, m));
    end
  endtask

  task automatic test_comb();
    int v;
    load_m(2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      v = $urandom_range(0, 511);
      vaddr = 10'(v);
      if (LAT0 == 0) #1;
      else begin
        @(posedge clk);
        #1;
      end
      checks++;
      if (int'(paddr0) !== ref_dec(v, 9, m)) begin
        errors++;
        $display("FAIL comb v=%0d got %0h exp %0h", v, paddr0, ref_dec(v, 9, m));
      end
    end
  endtask

  task automatic test_reset_mid();
    int v;
    int v2;
    load_m(2);
    v = $urandom_range(1, 511);
    while (ref_dec(v, 9, m) == 0) v = $urandom_range(1, 511);
    apply(v);
    checks++;
    if (paddr === 9'd0) begin errors++; $display("FAIL pre_reset got %0h exp nonzero", paddr); end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (paddr !== 9'd0) begin errors++; $display("FAIL async_reset got %0h exp 0", paddr); end
    @(negedge clk);
    v2 = $urandom_range(0, 511);
    vaddr = 10'(v2);
    #2;
    rst = 1'b0;
    repeat (LAT) @(posedge clk);
    #1;
    checks++;
    if (int'(paddr) !== ref_dec(v2, 9, m)) begin
      errors++;
      $display("FAIL post_reset got %0h exp %0h", paddr, ref_dec(v2, 9, m));
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_complement();
    test_bitmap8();
    test_random_sweep();
    test_back_to_back();
    test_comb();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
